// File: rtl/uop_pkg.sv
// Shared micro-op definitions for the decode/queue boundary.
// Holds the machine-width constants, the uop record and the packer's state type.
package uop_pkg;

    localparam int SUPER_SCALAR_WIDTH = 2;
    localparam int MAX_CRACK          = 4;
    localparam int INSTR_Q_WIDTH      = 8;
    localparam int INSTR_Q_DEPTH      = 16;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  rd;
        logic [15:0] imm;
    } uop_insn;

    typedef logic [$clog2(MAX_CRACK+1)-1:0] crack_cnt_t;

    // IDLE means no held uops; DRAIN means some remain to be enqueued.
    typedef enum logic {
        PACK_IDLE  = 1'b0,
        PACK_DRAIN = 1'b1
    } pack_state_e;

    // Largest of three widths, used to size the grant arithmetic.
    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/uop_bundle_packer_if.sv
// Decoder-to-instruction-queue bundle interface seen by the packer.
// The master side is the decoder plus queue; the slave side is the packer.
interface uop_bundle_packer_if #(
    parameter int SS_WIDTH  = uop_pkg::SUPER_SCALAR_WIDTH,
    parameter int MAX_CRACK = uop_pkg::MAX_CRACK,
    parameter int Q_WIDTH   = uop_pkg::INSTR_Q_WIDTH,
    parameter int Q_DEPTH   = uop_pkg::INSTR_Q_DEPTH
);

    logic                               flush_in;
    logic                               bundle_valid_in;
    logic                               bundle_ready_out;
    uop_pkg::uop_insn                   uops_in      [SS_WIDTH][MAX_CRACK];
    logic [$clog2(MAX_CRACK+1)-1:0]     crack_cnt_in [SS_WIDTH];
    logic [$clog2(Q_DEPTH+1)-1:0]       q_size_in;
    uop_pkg::uop_insn                   q_out        [Q_WIDTH];
    logic [$clog2(Q_WIDTH+1)-1:0]       enq_out;
    logic                               busy_out;

    modport master (
        output flush_in,
        output bundle_valid_in,
        output uops_in,
        output crack_cnt_in,
        output q_size_in,
        input  bundle_ready_out,
        input  q_out,
        input  enq_out,
        input  busy_out
    );

    modport slave (
        input  flush_in,
        input  bundle_valid_in,
        input  uops_in,
        input  crack_cnt_in,
        input  q_size_in,
        output bundle_ready_out,
        output q_out,
        output enq_out,
        output busy_out
    );

endinterface

// File: rtl/uop_bundle_packer_compactor.sv
// Squeezes a cracked bundle into program order with no gaps.
// Counts above MAX_CRACK are clamped before they contribute to the prefix sums.
module uop_compactor #(
    parameter int SS_WIDTH  = uop_pkg::SUPER_SCALAR_WIDTH,
    parameter int MAX_CRACK = uop_pkg::MAX_CRACK,
    parameter int CNT_W     = $clog2(SS_WIDTH*MAX_CRACK+1)
) (
    input  uop_pkg::uop_insn                 uops_i     [SS_WIDTH][MAX_CRACK],
    input  logic [$clog2(MAX_CRACK+1)-1:0]   crackCnt_i [SS_WIDTH],
    output uop_pkg::uop_insn                 dense_o    [SS_WIDTH*MAX_CRACK],
    output logic [CNT_W-1:0]                 total_o
);

    localparam int CCW   = $clog2(MAX_CRACK+1);
    localparam int TOTAL = SS_WIDTH * MAX_CRACK;

    logic [CCW-1:0]   clampedCnt [SS_WIDTH];
    logic [CNT_W-1:0] slotOffset [SS_WIDTH];

    // Clamp each slot's count and form the running offset where that slot starts.
    always_comb begin : prefixSum
        logic [CNT_W-1:0] running;
        running = '0;
        for (int s = 0; s < SS_WIDTH; s++) begin
            clampedCnt[s] = (crackCnt_i[s] > CCW'(MAX_CRACK)) ? CCW'(MAX_CRACK) : crackCnt_i[s];
            slotOffset[s] = running;
            running       = running + CNT_W'(clampedCnt[s]);
        end
        total_o = running;
    end

    // Each dense position picks the one live uop whose slot offset plus index lands on it.
    always_comb begin
        for (int j = 0; j < TOTAL; j++) begin
            dense_o[j] = '0;
            for (int s = 0; s < SS_WIDTH; s++) begin
                for (int k = 0; k < MAX_CRACK; k++) begin
                    if ((CCW'(k) < clampedCnt[s]) &&
                        ((slotOffset[s] + CNT_W'(k)) == CNT_W'(j))) begin
                        dense_o[j] = uops_i[s][k];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uop_bundle_packer.sv
// Packs a decoder bundle into the instruction queue's variable-width enqueue port.
// Holds leftovers across cycles and stalls the decoder until the bundle is fully handed off.
module uop_bundle_packer #(
    parameter int SS_WIDTH  = uop_pkg::SUPER_SCALAR_WIDTH,
    parameter int MAX_CRACK = uop_pkg::MAX_CRACK,
    parameter int Q_WIDTH   = uop_pkg::INSTR_Q_WIDTH,
    parameter int Q_DEPTH   = uop_pkg::INSTR_Q_DEPTH
) (
    input  logic                clk_in,
    input  logic                rst_in,
    uop_bundle_packer_if.slave  bus
);

    localparam int TOTAL  = SS_WIDTH * MAX_CRACK;
    localparam int CNT_W  = $clog2(TOTAL+1);
    localparam int QSZ_W  = $clog2(Q_DEPTH+1);
    localparam int ENQ_W  = $clog2(Q_WIDTH+1);
    localparam int MATH_W = uop_pkg::maxOf3(CNT_W, QSZ_W, ENQ_W) + 1;
    localparam int BUF_AW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    uop_pkg::pack_state_e state_q, state_d;
    logic [CNT_W-1:0]     remCnt_q, remCnt_d;
    logic [CNT_W-1:0]     cursor_q, cursor_d;
    uop_pkg::uop_insn     uopBuf_q [TOTAL];

    uop_pkg::uop_insn     denseUops [TOTAL];
    logic [CNT_W-1:0]     denseTotal;
    logic [MATH_W-1:0]    freeSlots;
    logic [MATH_W-1:0]    grant;
    logic                 readyInt;
    logic                 loadBundle;

    uop_compactor #(
        .SS_WIDTH  (SS_WIDTH),
        .MAX_CRACK (MAX_CRACK),
        .CNT_W     (CNT_W)
    ) compactor (
        .uops_i     (bus.uops_in),
        .crackCnt_i (bus.crack_cnt_in),
        .dense_o    (denseUops),
        .total_o    (denseTotal)
    );

    // State register: reset empties the packer so nothing held survives.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= uop_pkg::PACK_IDLE;
            remCnt_q <= '0;
            cursor_q <= '0;
        end else begin
            state_q  <= state_d;
            remCnt_q <= remCnt_d;
            cursor_q <= cursor_d;
        end
    end

    // Held bundle storage, written only when a new bundle is accepted.
    always_ff @(posedge clk_in) begin
        if (loadBundle) begin
            uopBuf_q <= denseUops;
        end
    end

    // Next-state: flush discards, accept reloads, otherwise advance by what was granted.
    always_comb begin
        state_d    = state_q;
        remCnt_d   = remCnt_q;
        cursor_d   = cursor_q;
        loadBundle = 1'b0;
        if (bus.flush_in) begin
            state_d  = uop_pkg::PACK_IDLE;
            remCnt_d = '0;
            cursor_d = '0;
        end else if (bus.bundle_valid_in && readyInt) begin
            loadBundle = 1'b1;
            remCnt_d   = denseTotal;
            cursor_d   = '0;
            state_d    = (denseTotal != '0) ? uop_pkg::PACK_DRAIN : uop_pkg::PACK_IDLE;
        end else begin
            remCnt_d = remCnt_q - CNT_W'(grant);
            cursor_d = cursor_q + CNT_W'(grant);
            state_d  = (remCnt_d != '0) ? uop_pkg::PACK_DRAIN : uop_pkg::PACK_IDLE;
        end
    end

    // Outputs: grant is the smallest of held uops, port width and queue space, widened so nothing wraps.
    always_comb begin
        if (MATH_W'(bus.q_size_in) >= MATH_W'(Q_DEPTH)) begin
            freeSlots = '0;
        end else begin
            freeSlots = MATH_W'(Q_DEPTH) - MATH_W'(bus.q_size_in);
        end

        grant = MATH_W'(remCnt_q);
        if (grant > MATH_W'(Q_WIDTH)) grant = MATH_W'(Q_WIDTH);
        if (grant > freeSlots)        grant = freeSlots;
        if ((state_q == uop_pkg::PACK_IDLE) || bus.flush_in || rst_in) grant = '0;

        readyInt             = !bus.flush_in && !rst_in && (MATH_W'(remCnt_q) == grant);
        bus.bundle_ready_out = readyInt;
        bus.enq_out          = ENQ_W'(grant);
        bus.busy_out         = (remCnt_q != '0);

        for (int i = 0; i < Q_WIDTH; i++) begin
            logic [MATH_W-1:0] idx;
            idx = MATH_W'(cursor_q) + MATH_W'(i);
            if ((MATH_W'(i) < grant) && (idx < MATH_W'(TOTAL))) begin
                bus.q_out[i] = uopBuf_q[idx[BUF_AW-1:0]];
            end else begin
                bus.q_out[i] = '0;
            end
        end
    end

endmodule
